// File: rtl/fila_escrita_registradores.sv
// Write-back queue feeding the register bank write port.
// Buffers execute/memory results in order, drains at most one write per
// cycle into registered EscReg/Dado/RegWrite, and exposes a combinational
// bypass lookup so decode can see values not yet committed to the bank.
module fila_escrita_registradores #(
  parameter int unsigned PROFUNDIDADE = 4,
  parameter int unsigned LARGURA_DADO = 32,
  parameter int unsigned LARGURA_END  = 5
) (
  input  logic                                sys_clock,
  input  logic                                reset,
  input  logic                                EntValido,
  output logic                                EntPronto,
  input  logic [LARGURA_END-1:0]              EntReg,
  input  logic [LARGURA_DADO-1:0]             EntDado,
  input  logic                                Parar,
  output logic [LARGURA_END-1:0]              EscReg,
  output logic [LARGURA_DADO-1:0]             Dado,
  output logic                                RegWrite,
  input  logic [LARGURA_END-1:0]              ConsultaReg,
  output logic                                ConsultaAcerto,
  output logic [LARGURA_DADO-1:0]             ConsultaDado,
  output logic [$clog2(PROFUNDIDADE):0]       Ocupacao,
  output logic                                Vazia
);

  localparam int unsigned LARG_PTR  = (PROFUNDIDADE > 1) ? $clog2(PROFUNDIDADE) : 1;
  localparam int unsigned LARG_OCUP = $clog2(PROFUNDIDADE) + 1;

  // Queue storage and bookkeeping
  logic [LARGURA_END-1:0]  fila_reg_q  [PROFUNDIDADE];
  logic [LARGURA_DADO-1:0] fila_dado_q [PROFUNDIDADE];
  logic [LARG_PTR-1:0]     wr_ptr_q, wr_ptr_d;
  logic [LARG_PTR-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LARG_OCUP-1:0]    ocup_q, ocup_d;
  logic                    cheia_q, cheia_d;
  logic                    vazia_q, vazia_d;

  // Output stage
  logic [LARGURA_END-1:0]  esc_reg_q, esc_reg_d;
  logic [LARGURA_DADO-1:0] dado_q, dado_d;
  logic                    reg_write_q, reg_write_d;

  // Handshake decode
  logic aceita;
  logic armazena;
  logic retira;

  // Accept/store/pop decisions; register 0 is accepted but never stored
  always_comb begin
    aceita   = EntValido && !cheia_q;
    armazena = aceita && (EntReg != '0);
    retira   = !Parar && (ocup_q != '0);
  end

  // Next-state for pointers, occupancy, flags and output stage
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    ocup_d      = ocup_q;
    esc_reg_d   = esc_reg_q;
    dado_d      = dado_q;
    reg_write_d = 1'b0;

    if (armazena) begin
      wr_ptr_d = wr_ptr_q + LARG_PTR'(1);
    end

    if (retira) begin
      rd_ptr_d    = rd_ptr_q + LARG_PTR'(1);
      esc_reg_d   = fila_reg_q[rd_ptr_q];
      dado_d      = fila_dado_q[rd_ptr_q];
      reg_write_d = 1'b1;
    end

    case ({armazena, retira})
      2'b10:   ocup_d = ocup_q + LARG_OCUP'(1);
      2'b01:   ocup_d = ocup_q - LARG_OCUP'(1);
      default: ocup_d = ocup_q;
    endcase

    cheia_d = (ocup_d == LARG_OCUP'(PROFUNDIDADE));
    vazia_d = (ocup_d == '0);
  end

  // Control and output-stage registers; reset drops any in-flight write
  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ocup_q      <= '0;
      cheia_q     <= 1'b0;
      vazia_q     <= 1'b1;
      esc_reg_q   <= '0;
      dado_q      <= '0;
      reg_write_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ocup_q      <= ocup_d;
      cheia_q     <= cheia_d;
      vazia_q     <= vazia_d;
      esc_reg_q   <= esc_reg_d;
      dado_q      <= dado_d;
      reg_write_q <= reg_write_d;
    end
  end

  // Entry storage; only slots below the occupancy count are meaningful
  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(PROFUNDIDADE); i++) begin
        fila_reg_q[i]  <= '0;
        fila_dado_q[i] <= '0;
      end
    end else if (armazena) begin
      fila_reg_q[wr_ptr_q]  <= EntReg;
      fila_dado_q[wr_ptr_q] <= EntDado;
    end
  end

  // Bypass lookup: output stage first, then queue oldest to youngest so the
  // youngest matching entry wins
  always_comb begin
    logic [LARG_PTR-1:0] idx;
    ConsultaAcerto = 1'b0;
    ConsultaDado   = '0;
    idx            = '0;

    if (reg_write_q && (esc_reg_q == ConsultaReg)) begin
      ConsultaAcerto = 1'b1;
      ConsultaDado   = dado_q;
    end

    for (int i = 0; i < int'(PROFUNDIDADE); i++) begin
      idx = rd_ptr_q + LARG_PTR'(i);
      if ((LARG_OCUP'(i) < ocup_q) && (fila_reg_q[idx] == ConsultaReg)) begin
        ConsultaAcerto = 1'b1;
        ConsultaDado   = fila_dado_q[idx];
      end
    end

    if (ConsultaReg == '0) begin
      ConsultaAcerto = 1'b0;
      ConsultaDado   = '0;
    end
  end

  assign EntPronto = !cheia_q;
  assign Vazia     = vazia_q;
  assign Ocupacao  = ocup_q;
  assign EscReg    = esc_reg_q;
  assign Dado      = dado_q;
  assign RegWrite  = reg_write_q;

endmodule
